uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_rr_select.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 132 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and state encoding for the UART transmit arbiter
package uart_pkg;

    localparam int DBITS = 8;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_t;

endpackage

// File: rtl/uart_rr_select.sv
// rtl/uart_rr_select.sv - cyclic first-set search starting from a base index
module uart_rr_select #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  base,
    output logic [NREQ-1:0] onehot,
    output logic            found
);

    // Walk the request vector from base, wrapping at NREQ, and keep the first hit.
    always_comb begin
        logic [IDW:0]   sum;
        logic [IDW-1:0] idx;
        onehot = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, base} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            idx = sum[IDW-1:0];
            if (!found && req[idx]) begin
                onehot[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - message-level round-robin arbiter feeding a UART transmit FIFO
module uart_tx_arbiter #(
    parameter int DBITS   = uart_pkg::DBITS,
    parameter int NREQ    = uart_pkg::NREQ,
    parameter int IDW     = uart_pkg::IDW,
    parameter int TIMEOUT = 1024,
    parameter int TO_BITS = 11
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*DBITS-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  tx_full,
    output logic                  write_uart,
    output logic [DBITS-1:0]      write_data,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic                  timeout_err,
    output logic [IDW-1:0]        err_id
);

    import uart_pkg::*;

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [NREQ-1:0]   grant_q;
    logic [IDW-1:0]    gid_q;
    logic [IDW-1:0]    rr_ptr;
    logic [TO_BITS-1:0] stall_cnt;

    logic [NREQ-1:0]   sel_oh;
    logic              sel_found;
    logic [IDW-1:0]    sel_id;
    logic [IDW-1:0]    ptr_after_gid;

    logic              xfer;
    logic              hs;
    logic              hs_last;
    logic              stall;
    logic              tmo;

    uart_rr_select #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_select (
        .req    (req_valid),
        .base   (rr_ptr),
        .onehot (sel_oh),
        .found  (sel_found)
    );

    // Encode the selected one-hot into an index so the owner can be stored compactly.
    always_comb begin
        sel_id = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (sel_oh[k]) begin
                sel_id = IDW'(k);
            end
        end
    end

    // Transfer datapath: ready, handshake, write strobe and stall/timeout detection.
    always_comb begin
        xfer          = (state == ST_XFER) && RST;
        req_ready     = (xfer && !tx_full) ? grant_q : '0;
        hs            = |(req_valid & req_ready);
        hs_last       = hs && req_last[gid_q];
        stall         = xfer && !hs && !tx_full;
        tmo           = stall && (stall_cnt == TO_BITS'(TIMEOUT - 1));
        write_uart    = hs;
        write_data    = hs ? req_data[gid_q*DBITS +: DBITS] : '0;
        busy          = xfer;
        grant         = grant_q;
        ptr_after_gid = (gid_q == IDW'(NREQ - 1)) ? '0 : gid_q + 1'b1;
    end

    // Next-state logic: grant on any request in IDLE, release on last byte or timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (sel_found)     state_nxt = ST_XFER;
            ST_XFER: if (hs_last || tmo) state_nxt = ST_IDLE;
            default:                    state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Owner, round-robin pointer, stall counter and error reporting.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            grant_q     <= '0;
            gid_q       <= '0;
            rr_ptr      <= '0;
            stall_cnt   <= '0;
            timeout_err <= 1'b0;
            err_id      <= '0;
        end else begin
            timeout_err <= tmo;
            if (tmo) begin
                err_id <= gid_q;
            end
            if (state == ST_IDLE) begin
                if (sel_found) begin
                    grant_q   <= sel_oh;
                    gid_q     <= sel_id;
                    stall_cnt <= '0;
                end
            end else begin
                if (hs_last || tmo) begin
                    grant_q   <= '0;
                    rr_ptr    <= ptr_after_gid;
                    stall_cnt <= '0;
                end else if (hs) begin
                    stall_cnt <= '0;
                end else if (stall) begin
                    stall_cnt <= stall_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter against a message-level model
module tb_uart_tx_arbiter;

    localparam int DBITS   = 8;
    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 16;
    localparam int TO_BITS = 11;

    logic                  CLK = 1'b0;
    logic                  RST = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*DBITS-1:0] req_data = '0;
    logic [NREQ-1:0]       req_last = '0;
    logic [NREQ-1:0]       req_ready;
    logic                  tx_full = 1'b0;
    logic                  write_uart;
    logic [DBITS-1:0]      write_data;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic                  timeout_err;
    logic [IDW-1:0]        err_id;

    always #5 CLK = ~CLK;

    uart_tx_arbiter #(
        .DBITS   (DBITS),
        .NREQ    (NREQ),
        .IDW     (IDW),
        .TIMEOUT (TIMEOUT),
        .TO_BITS (TO_BITS)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_full     (tx_full),
        .write_uart  (write_uart),
        .write_data  (write_data),
        .grant       (grant),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_id      (err_id)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Requester-side messages: each requester presents mbuf[i][pos[i]] until mlen[i] bytes go out.
    logic [7:0] mbuf [NREQ][8];
    int         mlen [NREQ];
    int         pos  [NREQ];
    int         hold_cnt [NREQ];
    bit         mute [NREQ];
    bit         drv_rst  = 1'b0;
    bit         drv_full = 1'b0;

    // Reference model: who owns the UART, where the next search starts, stall count.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;
    bit m_terr  = 1'b0;
    int m_eid   = 0;

    typedef struct {
        int         id;
        logic [7:0] d;
        int         cyc;
    } wr_t;

    wr_t wlog[$];
    int  done_ids[$];
    int  cyc      = 0;
    int  terr_cyc = -1;
    int  terr_cnt = 0;
    int  terr_eid = -1;

    task automatic set_msg(input int id, input int n, input logic [31:0] bytes);
        for (int j = 0; j < n; j++) begin
            mbuf[id][j] = bytes[j*8 +: 8];
        end
        mlen[id] = n;
        pos[id]  = 0;
    endtask

    function automatic bit pending();
        bit p;
        p = (m_owner >= 0);
        for (int i = 0; i < NREQ; i++) begin
            if (mlen[i] > 0) p = 1'b1;
        end
        return p;
    endfunction

    // One clock: drive at negedge, compare outputs against the model, then advance the model.
    task automatic step();
        logic            exp_busy;
        logic [NREQ-1:0] exp_ready;
        logic [NREQ-1:0] exp_grant;
        logic            exp_hs;
        logic [7:0]      exp_data;
        bit              found;
        int              idx;
        @(negedge CLK);
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = (pos[i] < mlen[i]) && !mute[i] && (hold_cnt[i] == 0);
            req_data[i*DBITS +: DBITS] = (pos[i] < mlen[i]) ? mbuf[i][pos[i]] : 8'h00;
            req_last[i] = (mlen[i] > 0) && (pos[i] == mlen[i] - 1);
        end
        tx_full = drv_full;
        RST     = drv_rst;
        #1;
        exp_busy  = drv_rst && (m_owner >= 0);
        exp_grant = (m_owner >= 0) ? (NREQ'(1) << m_owner) : '0;
        exp_ready = (exp_busy && !drv_full) ? exp_grant : '0;
        exp_hs    = exp_busy && !drv_full && req_valid[m_owner];
        exp_data  = exp_hs ? mbuf[m_owner][pos[m_owner]] : 8'h00;
        check_eq("grant", grant, exp_grant);
        check_eq("busy", busy, exp_busy);
        check_eq("req_ready", req_ready, exp_ready);
        check_eq("write_uart", write_uart, exp_hs);
        check_eq("write_data", write_data, exp_data);
        check_eq("timeout_err", timeout_err, m_terr);
        check_eq("err_id", err_id, m_eid);
        if (write_uart) wlog.push_back('{m_owner, write_data, cyc});
        if (timeout_err) begin
            terr_cyc = cyc;
            terr_cnt++;
            terr_eid = err_id;
        end
        if (!drv_rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_cnt   = 0;
            m_terr  = 1'b0;
            m_eid   = 0;
            for (int i = 0; i < NREQ; i++) pos[i] = 0;
        end else begin
            m_terr = 1'b0;
            if (m_owner < 0) begin
                found = 1'b0;
                for (int k = 0; k < NREQ; k++) begin
                    idx = (m_ptr + k) % NREQ;
                    if (!found && req_valid[idx]) begin
                        found   = 1'b1;
                        m_owner = idx;
                        m_cnt   = 0;
                    end
                end
            end else if (exp_hs) begin
                pos[m_owner]++;
                m_cnt = 0;
                if (pos[m_owner] == mlen[m_owner]) begin
                    done_ids.push_back(m_owner);
                    mlen[m_owner] = 0;
                    pos[m_owner]  = 0;
                    m_ptr   = (m_owner + 1) % NREQ;
                    m_owner = -1;
                end
            end else if (!drv_full) begin
                if (m_cnt == TIMEOUT - 1) begin
                    m_terr = 1'b1;
                    m_eid  = m_owner;
                    mlen[m_owner] = 0;
                    pos[m_owner]  = 0;
                    m_ptr   = (m_owner + 1) % NREQ;
                    m_owner = -1;
                    m_cnt   = 0;
                end else begin
                    m_cnt++;
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (hold_cnt[i] > 0) hold_cnt[i]--;
        end
        cyc++;
    endtask

    task automatic do_reset();
        for (int i = 0; i < NREQ; i++) begin
            mlen[i] = 0; pos[i] = 0; hold_cnt[i] = 0; mute[i] = 1'b0;
        end
        drv_full = 1'b0;
        drv_rst  = 1'b0;
        step();
        step();
        drv_rst = 1'b1;
        wlog.delete();
        done_ids.delete();
        terr_cnt = 0;
        terr_cyc = -1;
    endtask

    task automatic drain(input string tag, input int max);
        int k = 0;
        while (pending() && k < max) begin
            step();
            k++;
        end
        check_eq(tag, pending(), 0);
    endtask

    task automatic wait_writes(input string tag, input int n, input int max);
        int k = 0;
        while (wlog.size() < n && k < max) begin
            step();
            k++;
        end
        check_eq(tag, wlog.size(), n);
    endtask

    int hs_cyc;

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            mlen[i] = 0; pos[i] = 0; hold_cnt[i] = 0; mute[i] = 1'b0;
        end
        @(posedge CLK);

        // Reset state and single requester, three bytes back to back.
        do_reset();
        set_msg(0, 3, 32'h00434241);
        drain("single_drain", 20);
        check_eq("single_count", wlog.size(), 3);
        if (wlog.size() == 3) begin
            check_eq("single_b0", wlog[0].d, 8'h41);
            check_eq("single_b1", wlog[1].d, 8'h42);
            check_eq("single_b2", wlog[2].d, 8'h43);
            check_eq("single_gap", wlog[2].cyc - wlog[0].cyc, 2);
        end
        step();
        check_eq("single_grant_after", grant, 0);
        check_eq("single_busy_after", busy, 0);

        // Contention from reset, then a round that starts at requester 3.
        do_reset();
        set_msg(0, 2, 32'h0000a1a0);
        set_msg(1, 2, 32'h0000b1b0);
        set_msg(2, 2, 32'h0000c1c0);
        drain("cont_drain", 40);
        set_msg(3, 2, 32'h0000d1d0);
        set_msg(0, 2, 32'h0000e1e0);
        drain("cont_drain2", 40);
        check_eq("cont_count", done_ids.size(), 5);
        if (done_ids.size() == 5) begin
            check_eq("cont_ord0", done_ids[0], 0);
            check_eq("cont_ord1", done_ids[1], 1);
            check_eq("cont_ord2", done_ids[2], 2);
            check_eq("cont_ord3", done_ids[3], 3);
            check_eq("cont_ord4", done_ids[4], 0);
        end

        // Backpressure for 50 cycles mid-message.
        do_reset();
        set_msg(1, 4, 32'h44332211);
        wait_writes("bp_first2", 2, 10);
        drv_full = 1'b1;
        repeat (50) step();
        drv_full = 1'b0;
        drain("bp_drain", 20);
        check_eq("bp_count", wlog.size(), 4);
        if (wlog.size() == 4) begin
            check_eq("bp_b2", wlog[2].d, 8'h33);
            check_eq("bp_b3", wlog[3].d, 8'h44);
        end
        check_eq("bp_no_timeout", terr_cnt, 0);

        // Timeout: requester 2 sends one byte then goes silent.
        do_reset();
        set_msg(2, 3, 32'h00777675);
        wait_writes("to_first", 1, 10);
        hs_cyc = (wlog.size() > 0) ? wlog[0].cyc : 0;
        mute[2] = 1'b1;
        repeat (25) step();
        mute[2] = 1'b0;
        check_eq("to_latency", terr_cyc - hs_cyc, TIMEOUT + 1);
        check_eq("to_pulses", terr_cnt, 1);
        check_eq("to_err_id", terr_eid, 2);
        check_eq("to_released", grant, 0);

        // Reset after two of four bytes; the message is re-sent from its first byte.
        do_reset();
        set_msg(0, 4, 32'h5a595857);
        wait_writes("rst_first2", 2, 10);
        drv_rst = 1'b0;
        step();
        drv_rst = 1'b1;
        step();
        check_eq("rst_grant", grant, 0);
        check_eq("rst_write", write_uart, 0);
        wlog.delete();
        drain("rst_drain", 20);
        check_eq("rst_resend_count", wlog.size(), 4);
        if (wlog.size() == 4) begin
            check_eq("rst_resend_b0", wlog[0].d, 8'h57);
            check_eq("rst_resend_b3", wlog[3].d, 8'h5a);
        end

        // Randomized traffic with backpressure, silences and occasional resets.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (mlen[i] == 0 && ($urandom % 6) == 0) set_msg(i, 1 + ($urandom % 4), $urandom);
                if (hold_cnt[i] == 0 && ($urandom % 40) == 0) hold_cnt[i] = $urandom_range(1, 24);
            end
            drv_full = (($urandom % 4) == 0);
            drv_rst  = (($urandom % 700) != 0);
            step();
        end
        drv_rst  = 1'b1;
        drv_full = 1'b0;
        for (int i = 0; i < NREQ; i++) hold_cnt[i] = 0;
        drain("rand_drain", 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
